// File: rtl/parity_check_stream_if.sv
// Link-side word stream into the parity checker: 23-bit word, qualify strobe, end-of-event flag.
// No backpressure: the master drives one word per valid cycle and the slave must take it.
interface parity_check_stream_if;
    logic [22:0] data;
    logic        valid;
    logic        eoe;

    modport master (output data, valid, eoe);
    modport slave  (input  data, valid, eoe);
endinterface

// File: rtl/parity_check_stream.sv
// Per-event running-parity checker; reports 1 cycle after the trailer, err_count/sticky_err 1 cycle after the report.
// No backpressure (every valid word is consumed); `PARITY_CHK_ODD_EN selects odd parity, default even.
module parity_check_stream #(
    parameter int MAX_WORDS = 1024,
    parameter int CNT_W     = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    parity_check_stream_if.slave  link,
    input  logic                  clear_cnt,
    output logic                  event_done,
    output logic                  parity_err,
    output logic                  length_err,
    output logic                  sticky_err,
    output logic [CNT_W-1:0]      err_count,
    output logic                  busy
);
    localparam int WC_W = $clog2(MAX_WORDS + 1);

`ifdef PARITY_CHK_ODD_EN
    localparam logic PAR_BIAS = 1'b1;
`else
    localparam logic PAR_BIAS = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, ACCUM, OVFL} state_t;

    state_t            state, state_nxt;
    logic              acc, acc_nxt;
    logic [WC_W-1:0]   word_cnt, word_cnt_nxt;
    logic              done_nxt, perr_nxt, lerr_nxt;
    logic              payload, trailer, at_max, err_hit;

    assign payload = link.valid & ~link.eoe;
    assign trailer = link.valid &  link.eoe;
    assign at_max  = (word_cnt == WC_W'(MAX_WORDS));
    assign busy    = (state != IDLE);
    assign err_hit = parity_err | length_err;

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (trailer) begin
            state_nxt = IDLE;
        end else if (payload) begin
            case (state)
                IDLE:    state_nxt = ACCUM;
                ACCUM:   state_nxt = at_max ? OVFL : ACCUM;
                OVFL:    state_nxt = OVFL;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // The word that trips overflow is discarded too, so acc/word_cnt only move while staying below OVFL.
    always_comb begin
        acc_nxt      = acc;
        word_cnt_nxt = word_cnt;
        done_nxt     = 1'b0;
        perr_nxt     = 1'b0;
        lerr_nxt     = 1'b0;
        if (trailer) begin
            done_nxt     = 1'b1;
            lerr_nxt     = (state == OVFL);
            perr_nxt     = (state != OVFL) && ((acc ^ PAR_BIAS) != link.data[0]);
            acc_nxt      = 1'b0;
            word_cnt_nxt = '0;
        end else if (payload && state_nxt != OVFL) begin
            acc_nxt      = acc ^ (^link.data);
            word_cnt_nxt = word_cnt + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            acc        <= 1'b0;
            word_cnt   <= '0;
            event_done <= 1'b0;
            parity_err <= 1'b0;
            length_err <= 1'b0;
        end else begin
            acc        <= acc_nxt;
            word_cnt   <= word_cnt_nxt;
            event_done <= done_nxt;
            parity_err <= perr_nxt;
            length_err <= lerr_nxt;
        end
    end

    // A clear landing on a report cycle keeps that report's error.
    always_ff @(posedge clock) begin
        if (reset) begin
            err_count  <= '0;
            sticky_err <= 1'b0;
        end else if (clear_cnt) begin
            err_count  <= err_hit ? CNT_W'(1) : '0;
            sticky_err <= err_hit;
        end else if (err_hit) begin
            sticky_err <= 1'b1;
            if (err_count != {CNT_W{1'b1}})
                err_count <= err_count + 1'b1;
        end
    end
endmodule

// File: tb/tb_parity_check_stream.sv
// Directed bench for parity_check_stream (MAX_WORDS=4, CNT_W=2) with a report scoreboard.
module tb_parity_check_stream;
    localparam int MW = 4;
    localparam int CW = 2;
`ifdef PARITY_CHK_ODD_EN
    localparam bit ODD = 1'b1;
`else
    localparam bit ODD = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          reset;
    logic          clear_cnt;
    logic          event_done, parity_err, length_err, sticky_err, busy;
    logic [CW-1:0] err_count;

    parity_check_stream_if lnk ();

    parity_check_stream #(.MAX_WORDS(MW), .CNT_W(CW)) dut (
        .clock      (clock),
        .reset      (reset),
        .link       (lnk),
        .clear_cnt  (clear_cnt),
        .event_done (event_done),
        .parity_err (parity_err),
        .length_err (length_err),
        .sticky_err (sticky_err),
        .err_count  (err_count),
        .busy       (busy)
    );

    always #5 clock = ~clock;

    int n_assert = 0;
    int n_fail   = 0;

    // Scoreboard entries: {expected parity_err, expected length_err}
    logic [1:0] exp_q[$];

    bit m_acc;
    int m_cnt;
    bit m_ovf;
    int exp_cnt;
    bit exp_sticky;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        lnk.valid = 1'b0;
        repeat (n) tick();
    endtask

    task automatic send_word(input logic [22:0] d);
        lnk.data  = d;
        lnk.valid = 1'b1;
        lnk.eoe   = 1'b0;
        if (!m_ovf) begin
            if (m_cnt == MW) m_ovf = 1'b1;
            else begin
                m_acc = m_acc ^ (^d);
                m_cnt++;
            end
        end
        tick();
        lnk.valid = 1'b0;
    endtask

    // Returns whether the model expects this event to be counted as an error.
    task automatic send_trailer(input bit p, output bit is_err);
        bit ep, el;
        el = m_ovf;
        ep = !m_ovf && ((m_acc ^ ODD) != p);
        exp_q.push_back({ep, el});
        is_err = ep | el;
        m_acc = 1'b0; m_cnt = 0; m_ovf = 1'b0;
        lnk.data  = {22'h2AAAAA, p};
        lnk.valid = 1'b1;
        lnk.eoe   = 1'b1;
        tick();
        lnk.valid = 1'b0;
        lnk.eoe   = 1'b0;
    endtask

    task automatic trailer_counted(input bit p);
        bit e;
        send_trailer(p, e);
        if (e) begin
            exp_sticky = 1'b1;
            if (exp_cnt < (1 << CW) - 1) exp_cnt++;
        end
        idle(2);
    endtask

    task automatic check_counters(input string tag);
        check({tag, "_cnt"}, 32'(err_count), 32'(exp_cnt));
        check({tag, "_sticky"}, 32'(sticky_err), 32'(exp_sticky));
    endtask

    task automatic do_clear();
        clear_cnt = 1'b1;
        tick();
        clear_cnt = 1'b0;
        exp_cnt = 0;
        exp_sticky = 1'b0;
    endtask

    always @(negedge clock) begin
        if (!reset) begin
            if (event_done) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 32'(event_done), 32'd0);
                end else begin
                    logic [1:0] e;
                    e = exp_q.pop_front();
                    check("rpt_parity_err", 32'(parity_err), 32'(e[1]));
                    check("rpt_length_err", 32'(length_err), 32'(e[0]));
                end
            end else if (parity_err || length_err) begin
                check("err_without_done", 32'({parity_err, length_err}), 32'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit e;
        reset = 1'b1; clear_cnt = 1'b0;
        lnk.data = '0; lnk.valid = 1'b0; lnk.eoe = 1'b0;
        m_acc = 0; m_cnt = 0; m_ovf = 0; exp_cnt = 0; exp_sticky = 0;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        check("rst_outputs", 32'({event_done, parity_err, length_err, sticky_err, busy}), 32'd0);
        check("rst_err_count", 32'(err_count), 32'd0);

        // Clean event
        send_word(23'h000001);
        check("clean_busy", 32'(busy), 32'd1);
        send_word(23'h000003);
        send_word(23'h7FFFFF);
        trailer_counted(1'b0);
        check_counters("clean");
        check("clean_busy_after", 32'(busy), 32'd0);

        // Bad parity, then clear
        send_word(23'h000001);
        send_word(23'h000003);
        send_word(23'h7FFFFF);
        trailer_counted(1'b1);
        check_counters("bad");
        do_clear();
        check_counters("bad_cleared");

        // Back-to-back with gaps
        send_word(23'h000003);
        idle(2);
        send_word(23'h000005);
        idle(1);
        send_trailer(1'b0, e);
        send_word(23'h000001);
        check("b2b_busy", 32'(busy), 32'd1);
        trailer_counted(1'b0);
        if (e) exp_cnt++;
        if (e) exp_sticky = 1'b1;
        check_counters("b2b");

        // Overflow
        do_clear();
        for (int i = 0; i < 6; i++) begin
            send_word(23'(i * 7 + 1));
            check("ovfl_busy", 32'(busy), 32'd1);
        end
        trailer_counted(1'b0);
        check("ovfl_busy_after", 32'(busy), 32'd0);
        check_counters("ovfl");

        // Saturation
        do_clear();
        for (int i = 0; i < 5; i++) begin
            send_word(23'h000001);
            trailer_counted(~(m_acc ^ ODD));
            check_counters("sat");
        end
        check("sat_hold", 32'(err_count), 32'd3);

        // Clear coinciding with a bad report keeps the new error
        send_word(23'h000001);
        send_trailer(~(m_acc ^ ODD), e);
        clear_cnt = 1'b1;
        tick();
        clear_cnt = 1'b0;
        tick();
        exp_cnt = 1; exp_sticky = 1'b1;
        check_counters("coincide");

        // Empty event
        do_clear();
        trailer_counted(1'b0);
        check_counters("empty");

        // Reset mid-event drops it silently
        do_clear();
        send_word(23'h000001);
        send_word(23'h000002);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        m_acc = 0; m_cnt = 0; m_ovf = 0;
        check("midrst_busy", 32'(busy), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("midrst_no_done", 32'(event_done), 32'd0);
        end
        send_word(23'h000001);
        trailer_counted(1'b1);
        check_counters("after_rst");

        idle(3);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
